// File: rtl/btb_pkg.sv
// Shared types and constants for the BTB update path: 2-bit direction
// counter encoding, default index width and the BTB write record.
package btb_pkg;

    localparam int BTB_IDX_W = 4;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    typedef struct packed {
        logic [BTB_IDX_W-1:0] idx;
        logic [31:0]          target;
    } btb_wr_t;

    // Saturating step of a direction counter toward the resolved outcome.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == ST) ? ST : ctr + 2'd1;
        end
        return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/btb_wr_fifo.sv
// Small FIFO of pending BTB target writes; head entry is presented to the BTB.
// Push is refused when full, pop ignored when empty; pointers wrap modulo depth.
module btb_wr_fifo
    import btb_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic    CLK,
    input  logic    RESET,
    input  logic    push,
    input  btb_wr_t push_data,
    input  logic    pop,
    output btb_wr_t head,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    btb_wr_t            mem [BUF_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full    = (count == CNT_W'(BUF_DEPTH));
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = mem[rd_ptr];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/btb_update_unit.sv
// Branch resolution / predictor update: direction counters, mispredict flush
// and queued BTB target writes. BTB_UPD_STATS_EN adds branch/mispredict counters.
module btb_update_unit
    import btb_pkg::*;
#(
    parameter int IDX_W     = BTB_IDX_W,
    parameter int BUF_DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [31:0]      IF_PC_4,
    output logic             IF_Predict_Taken,
    input  logic             EX_Valid,
    output logic             EX_Ready,
    input  logic [31:0]      EX_PC_4,
    input  logic             EX_Taken,
    input  logic [31:0]      EX_Target,
    input  logic             EX_Pred_Taken,
    input  logic [31:0]      EX_Pred_Addr,
    output logic             Flush,
    output logic [31:0]      Redirect_PC,
    output logic             BTB_Wr_Valid,
    input  logic             BTB_Wr_Ready,
    output logic [IDX_W-1:0] BTB_Wr_Idx,
    output logic [31:0]      BTB_Wr_Target
`ifdef BTB_UPD_STATS_EN
    ,
    output logic [31:0]      Branch_Count,
    output logic [31:0]      Mispredict_Count
`endif
);

    localparam int N_ENT = 1 << IDX_W;

    logic [1:0]       ctr [N_ENT];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             acc;
    logic             dir_miss;
    logic             tgt_miss;
    logic             mispredict;
    logic             enqueue;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             flush_r;
    btb_wr_t          push_ent;
    btb_wr_t          head_ent;
    logic             unused_if_pc;

    always_comb begin
        if_idx       = IF_PC_4[IDX_W+1:2];
        ex_idx       = EX_PC_4[IDX_W+1:2];
        unused_if_pc = ^{IF_PC_4[31:IDX_W+2], IF_PC_4[1:0]};

        IF_Predict_Taken = ctr[if_idx][1];

        // No pop bypass: a full buffer stalls EX even if the BTB drains this cycle.
        EX_Ready   = !fifo_full;
        acc        = EX_Valid && !fifo_full;
        dir_miss   = (EX_Pred_Taken != EX_Taken);
        tgt_miss   = EX_Taken && EX_Pred_Taken && (EX_Pred_Addr != EX_Target);
        mispredict = acc && (dir_miss || tgt_miss);
        enqueue    = acc && EX_Taken && (!EX_Pred_Taken || (EX_Pred_Addr != EX_Target));

        push_ent.idx    = ex_idx;
        push_ent.target = EX_Target;

        fifo_pop      = !fifo_empty && BTB_Wr_Ready;
        BTB_Wr_Valid  = !fifo_empty;
        BTB_Wr_Idx    = head_ent.idx;
        BTB_Wr_Target = head_ent.target;

        // A pulse already registered never escapes into a reset cycle.
        Flush = flush_r && !RESET;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < N_ENT; i++) begin
                ctr[i] <= WNT;
            end
            flush_r     <= 1'b0;
            Redirect_PC <= '0;
        end else begin
            if (acc) begin
                ctr[ex_idx] <= ctr_next(ctr[ex_idx], EX_Taken);
            end
            flush_r     <= mispredict;
            Redirect_PC <= mispredict ? (EX_Taken ? EX_Target : EX_PC_4) : '0;
        end
    end

`ifdef BTB_UPD_STATS_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            Branch_Count     <= '0;
            Mispredict_Count <= '0;
        end else begin
            if (acc) begin
                Branch_Count <= Branch_Count + 32'd1;
            end
            if (mispredict) begin
                Mispredict_Count <= Mispredict_Count + 32'd1;
            end
        end
    end
`endif

    btb_wr_fifo #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_wr_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (enqueue),
        .push_data (push_ent),
        .pop       (fifo_pop),
        .head      (head_ent),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
